dmem_rr_sram: RTL and testbench

- Synthesizable multi-channel data memory that sits directly downstream of the gpu data-memory interface.
- Consumes the per-channel read/write valid/address/data buses the cores produce, and returns one-cycle ready pulses plus read data.
- Arbitrates all channels round-robin onto one single-ported SRAM array, with configurable read latency.
- Includes a host port, with priority, for loading operands and reading back results. Replaces the behavioural memory used at gpu top level.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_rr_arbiter.sv | 31 +++
 rtl/dmem_rr_sram.sv | 190 +++++++++++++++++++
 tb/tb_dmem_rr_sram.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the round-robin data memory: channel state, read-pipeline entry, and
// a helper that sizes channel indices.
package dmem_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_BUSY = 2'd1,
    CH_HOLD = 2'd2
  } ch_state_e;

  // Pipeline entry fields are sized for the largest supported configuration.
  localparam int unsigned MaxChanBits = 8;
  localparam int unsigned MaxDataBits = 64;

  typedef struct packed {
    logic                   valid;
    logic [MaxChanBits-1:0] chan;
    logic [MaxDataBits-1:0] data;
  } rd_entry_t;

  function automatic int unsigned chan_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Combinational round-robin picker: first eligible channel at or above ptr, with wrap.
module dmem_rr_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CHAN_BITS    = chan_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] eligible,
  input  logic [CHAN_BITS-1:0]    ptr,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [CHAN_BITS-1:0]    next_ptr
);

  always_comb begin
    logic                 found;
    logic [CHAN_BITS-1:0] idx;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      idx = CHAN_BITS'((32'(ptr) + k) % NUM_CHANNELS);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = CHAN_BITS'((32'(idx) + 1) % NUM_CHANNELS);
      end
    end
  end

endmodule

// File: rtl/dmem_rr_sram.sv
// Multi-channel data memory: round-robin channel arbitration onto one single-ported array,
// host port with priority. Define DMEM_PERF_COUNTERS_EN to add rd/wr/conflict counters.
module dmem_rr_sram
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready,
  input  logic                              host_en,
  input  logic                              host_we,
  input  logic [ADDR_BITS-1:0]              host_addr,
  input  logic [DATA_BITS-1:0]              host_wdata,
  output logic [DATA_BITS-1:0]              host_rdata
`ifdef DMEM_PERF_COUNTERS_EN
  ,
  output logic [15:0]                       rd_count,
  output logic [15:0]                       wr_count,
  output logic [15:0]                       conflict_count
`endif
);

  localparam int unsigned CB    = chan_width(NUM_CHANNELS);
  localparam int unsigned Depth = 1 << ADDR_BITS;

  ch_state_e               state_q [NUM_CHANNELS];
  ch_state_e               state_d [NUM_CHANNELS];
  logic [CB-1:0]           ptr_q, ptr_d, arb_next;
  logic [NUM_CHANNELS-1:0] eligible, arb_grant, grant, rd_ready, wr_ready_q;
  logic                    gnt_any, gnt_write, gnt_read;
  logic [CB-1:0]           gnt_chan;
  logic [ADDR_BITS-1:0]    gnt_addr;
  logic [DATA_BITS-1:0]    gnt_wdata;
  logic [DATA_BITS-1:0]    mem_q [Depth];
  logic [DATA_BITS-1:0]    held_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    host_rdata_q;
  rd_entry_t               pipe_q [READ_LATENCY];
  rd_entry_t               pipe_in, pipe_out;
  logic                    unused_pipe_bits;

  // Grants are withheld during reset so held requests restart cleanly afterwards.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = !reset && (read_valid[i] || write_valid[i]) && (state_q[i] == CH_IDLE);
    end
  end

  dmem_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CHAN_BITS    (CB)
  ) u_arbiter (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .next_ptr (arb_next)
  );

  assign grant    = host_en ? '0 : arb_grant;
  assign gnt_any  = |grant;
  assign ptr_d    = gnt_any ? arb_next : ptr_q;
  assign gnt_read = gnt_any && !gnt_write;

  // A channel with both valids is served as a write; its read stays pending.
  always_comb begin
    gnt_write = 1'b0;
    gnt_chan  = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (grant[i]) begin
        gnt_chan  = CB'(i);
        gnt_write = write_valid[i];
        gnt_addr  = write_valid[i] ? write_address[i*ADDR_BITS +: ADDR_BITS]
                                   : read_address[i*ADDR_BITS +: ADDR_BITS];
        gnt_wdata = write_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = gnt_read;
    pipe_in.chan  = MaxChanBits'(gnt_chan);
    pipe_in.data  = MaxDataBits'(mem_q[gnt_addr]);
  end

  assign pipe_out         = pipe_q[READ_LATENCY-1];
  assign unused_pipe_bits = ^pipe_out.data;

  always_comb begin
    rd_ready  = '0;
    read_data = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      rd_ready[i] = pipe_out.valid && (pipe_out.chan == MaxChanBits'(i));
      read_data[i*DATA_BITS +: DATA_BITS] = rd_ready[i] ? pipe_out.data[DATA_BITS-1:0]
                                                        : held_q[i];
    end
  end

  assign read_ready  = rd_ready;
  assign write_ready = wr_ready_q;
  assign host_rdata  = host_rdata_q;

  // HOLD keeps a just-served channel out for one cycle while its requester drops valid.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        CH_IDLE: if (grant[i]) state_d[i] = CH_BUSY;
        CH_BUSY: if (rd_ready[i] || wr_ready_q[i]) state_d[i] = CH_HOLD;
        CH_HOLD: state_d[i] = CH_IDLE;
        default: state_d[i] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      wr_ready_q   <= '0;
      host_rdata_q <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= CH_IDLE;
        held_q[i]  <= '0;
      end
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      wr_ready_q <= gnt_write ? grant : '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        if (rd_ready[i]) held_q[i] <= pipe_out.data[DATA_BITS-1:0];
      end
      pipe_q[0] <= pipe_in;
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
      if (host_en && !host_we) host_rdata_q <= mem_q[host_addr];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (host_en && host_we) begin
      mem_q[host_addr] <= host_wdata;
    end else if (gnt_write) begin
      mem_q[gnt_addr] <= gnt_wdata;
    end
  end

`ifdef DMEM_PERF_COUNTERS_EN
  logic conflict;

  always_comb begin
    int unsigned n_elig;
    n_elig = 0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      n_elig = n_elig + 32'(eligible[i]);
    end
    conflict = (n_elig > 1) || (host_en && (n_elig != 0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count       <= '0;
      wr_count       <= '0;
      conflict_count <= '0;
    end else begin
      if (gnt_read && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
      if (gnt_write && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (conflict && (conflict_count != 16'hFFFF)) conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_rr_sram.sv
// Self-checking bench for dmem_rr_sram: directed scenarios plus random traffic against a
// cycle-indexed reference model (memory array, return queue, per-channel free times).
module tb_dmem_rr_sram;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int RL  = 2;
  localparam int INF = 1 << 30;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    read_valid, read_ready, write_valid, write_ready;
  logic [NC*AB-1:0] read_address, write_address;
  logic [NC*DB-1:0] read_data, write_data;
  logic             host_en, host_we;
  logic [AB-1:0]    host_addr;
  logic [DB-1:0]    host_wdata, host_rdata;
`ifdef DMEM_PERF_COUNTERS_EN
  logic [15:0]      rd_count, wr_count, conflict_count;
`endif

  dmem_rr_sram #(
    .ADDR_BITS    (AB),
    .DATA_BITS    (DB),
    .NUM_CHANNELS (NC),
    .READ_LATENCY (RL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .read_valid     (read_valid),
    .read_address   (read_address),
    .read_ready     (read_ready),
    .read_data      (read_data),
    .write_valid    (write_valid),
    .write_address  (write_address),
    .write_data     (write_data),
    .write_ready    (write_ready),
    .host_en        (host_en),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata)
`ifdef DMEM_PERF_COUNTERS_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;

  // Reference model state.
  int mem [256];
  int ptr;
  int free_at [NC];
  int wr_due [NC];
  int held [NC];
  int exp_host;
  int rq_due [$];
  int rq_ch [$];
  int rq_data [$];
  int n_rd, n_wr, n_conf;

  // Requester state: kind 0 = none, 1 = read, 2 = write.
  int kind [NC];
  int addr_r [NC];
  int data_r [NC];
  int done_at [NC];
  int obs_rr [NC];
  bit auto_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NC; i++) begin
      read_valid[i]               = (kind[i] == 1);
      write_valid[i]              = (kind[i] == 2);
      read_address[i*AB +: AB]    = AB'(addr_r[i]);
      write_address[i*AB +: AB]   = AB'(addr_r[i]);
      write_data[i*DB +: DB]      = DB'(data_r[i]);
    end
  endtask

  task automatic set_req(input int ch, input int k, input int a, input int d);
    kind[ch]   = k;
    addr_r[ch] = a;
    data_r[ch] = d;
    pack();
  endtask

  // Expected outputs for the current cycle.
  task automatic compare();
    logic [NC-1:0]    er, ew;
    logic [NC*DB-1:0] ed;
    er = '0;
    ew = '0;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      er[rq_ch[0]]      = 1'b1;
      held[rq_ch[0]]    = rq_data[0];
      done_at[rq_ch[0]] = cyc;
      free_at[rq_ch[0]] = cyc + 2;
      void'(rq_due.pop_front());
      void'(rq_ch.pop_front());
      void'(rq_data.pop_front());
    end
    for (int i = 0; i < NC; i++) begin
      if (wr_due[i] == cyc) begin
        ew[i]      = 1'b1;
        done_at[i] = cyc;
        free_at[i] = cyc + 2;
      end
      ed[i*DB +: DB] = DB'(held[i]);
      if (read_ready[i] === 1'b1) obs_rr[i]++;
    end
    chk("read_ready", 32'(read_ready), 32'(er));
    chk("write_ready", 32'(write_ready), 32'(ew));
    chk("read_data", 32'(read_data), 32'(ed));
    chk("host_rdata", 32'(host_rdata), 32'(exp_host));
  endtask

  // Apply this cycle's inputs to the model at the end of the cycle.
  task automatic advance();
    bit elig [NC];
    int e, g, i;
    if (reset) begin
      rq_due.delete();
      rq_ch.delete();
      rq_data.delete();
      ptr = 0;
      for (int k = 0; k < NC; k++) begin
        free_at[k] = 0;
        wr_due[k]  = -1;
        held[k]    = 0;
      end
      exp_host = 0;
      n_rd = 0;
      n_wr = 0;
      n_conf = 0;
      return;
    end
    e = 0;
    for (int k = 0; k < NC; k++) begin
      elig[k] = (read_valid[k] || write_valid[k]) && (cyc >= free_at[k]);
      if (elig[k]) e++;
    end
    if (e > 1 || (host_en && e > 0)) n_conf++;
    if (host_en) begin
      if (host_we) mem[int'(host_addr)] = int'(host_wdata);
      else exp_host = mem[int'(host_addr)];
    end else begin
      g = -1;
      for (int k = 0; k < NC; k++) begin
        i = (ptr + k) % NC;
        if (g < 0 && elig[i]) g = i;
      end
      if (g >= 0) begin
        free_at[g] = INF;
        ptr = (g + 1) % NC;
        if (write_valid[g]) begin
          mem[addr_r[g]] = data_r[g] & 255;
          wr_due[g] = cyc + 1;
          n_wr++;
        end else begin
          rq_due.push_back(cyc + RL);
          rq_ch.push_back(g);
          rq_data.push_back(mem[addr_r[g]]);
          n_rd++;
        end
      end
    end
  endtask

  // Requesters keep valid through the cycle after ready, then drop it.
  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      if (kind[i] != 0 && done_at[i] == cyc - 2) kind[i] = 0;
      if (kind[i] == 0 && auto_req && done_at[i] < cyc - 2 && $urandom_range(0, 2) == 0) begin
        kind[i]   = int'($urandom_range(1, 2));
        addr_r[i] = int'($urandom_range(0, 31));
        data_r[i] = int'($urandom_range(0, 255));
      end
    end
    pack();
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    advance();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit all_idle();
    bit r;
    r = (rq_due.size() == 0);
    for (int i = 0; i < NC; i++) begin
      if (kind[i] != 0) r = 1'b0;
    end
    return r;
  endfunction

  initial begin
    reset      = 1'b1;
    host_en    = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    auto_req   = 1'b0;
    ptr        = 0;
    exp_host   = 0;
    n_rd = 0;
    n_wr = 0;
    n_conf = 0;
    for (int i = 0; i < NC; i++) begin
      kind[i] = 0; addr_r[i] = 0; data_r[i] = 0; done_at[i] = -10;
      free_at[i] = 0; wr_due[i] = -1; held[i] = 0; obs_rr[i] = 0;
    end
    pack();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Preload: addr 0..7 = index, the rest random.
    for (int a = 0; a < 256; a++) begin
      host_en    = 1'b1;
      host_we    = 1'b1;
      host_addr  = AB'(a);
      host_wdata = (a < 8) ? DB'(a) : DB'($urandom_range(0, 255));
      step();
    end
    host_we   = 1'b0;
    host_addr = 8'd5;
    step();
    host_en = 1'b0;
    chk("preload_addr5", 32'(host_rdata), 32'd5);

    // Channel 2 reads addr 5; valid stays high through HOLD, served exactly once.
    set_req(2, 1, 5, 0);
    repeat (8) step();
    chk("ch2_single_return", 32'(obs_rr[2]), 32'd1);
    chk("ch2_data", 32'(read_data[2*DB +: DB]), 32'd5);

    // Move the pointer back to 0, then all four channels read addr 0..3 together.
    set_req(3, 1, 7, 0);
    repeat (6) step();
    for (int i = 0; i < NC; i++) set_req(i, 1, i, 0);
    repeat (12) step();
    chk("four_returns", 32'(obs_rr[0] + obs_rr[1] + obs_rr[2] + obs_rr[3]), 32'd6);
    chk("ch3_data", 32'(read_data[3*DB +: DB]), 32'd3);

    // Write 0x2A to addr 16 on ch1 while ch3 reads the same address.
    set_req(1, 2, 16, 8'h2A);
    set_req(3, 1, 16, 0);
    repeat (10) step();
    chk("ch3_reads_2a", 32'(read_data[3*DB +: DB]), 32'h2A);

    // Host holds priority for three cycles while ch0 waits.
    set_req(0, 1, 1, 0);
    host_en   = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'd16;
    repeat (3) step();
    host_en = 1'b0;
    step();
    chk("host_reads_2a", 32'(host_rdata), 32'h2A);
    repeat (8) step();

    // Reset with a read in flight: flushed, outputs cleared, array kept.
    set_req(0, 1, 2, 0);
    set_req(1, 1, 3, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_reset_rdata", 32'(read_data), 32'd0);
    chk("post_reset_host", 32'(host_rdata), 32'd0);
    repeat (12) step();
    host_en   = 1'b1;
    host_addr = 8'd16;
    step();
    host_en = 1'b0;
    chk("array_kept_2a", 32'(host_rdata), 32'h2A);

    // Random traffic with occasional host accesses.
    auto_req = 1'b1;
    for (int t = 0; t < 500; t++) begin
      host_en    = ($urandom_range(0, 7) == 0);
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = AB'($urandom_range(0, 31));
      host_wdata = DB'($urandom_range(0, 255));
      step();
    end
    auto_req = 1'b0;
    host_en  = 1'b0;
    for (int t = 0; t < 200 && !all_idle(); t++) step();
    chk("drain_idle", 32'(all_idle()), 32'd1);

`ifdef DMEM_PERF_COUNTERS_EN
    chk("rd_count", 32'(rd_count), 32'(n_rd));
    chk("wr_count", 32'(wr_count), 32'(n_wr));
    chk("conflict_count", 32'(conflict_count), 32'(n_conf));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
